// File: rtl/telemetry_framer.sv
// Periodic/triggered telemetry packetiser: snapshots NUM_CH samples and sends
// HEADER, seq, payload bytes (big-endian per channel) and a mod-256 checksum.
module telemetry_framer #(
    parameter int          NUM_CH     = 2,
    parameter int          DATA_W     = 8,
    parameter int          PERIOD_CYC = 10000000,
    parameter logic [7:0]  HEADER     = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     enable,
    input  logic                     trig,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     tx_done,
    output logic [7:0]               tx_data,
    output logic                     tx_en,
    output logic                     busy,
    output logic                     frame_done,
    output logic [7:0]               seq,
    output logic [7:0]               ovr_cnt
);

    localparam int BPC  = DATA_W / 8;
    localparam int NPAY = NUM_CH * BPC;
    localparam int FLEN = NPAY + 3;
    localparam int CW   = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int IW   = $clog2(FLEN);

    // Handshake: a byte is offered while tx_en=1 and tx_data is held stable;
    // it is consumed in the cycle tx_done=1, after which tx_en drops for one
    // GAP cycle before the next byte is offered. tx_done with tx_en=0 is ignored.
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_GAP} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [NUM_CH*DATA_W-1:0]  snap_q, snap_d;
    logic [7:0]                seq_q, seq_d;
    logic [7:0]                ovr_q, ovr_d;
    logic                      fd_q, fd_d;
    logic                      tick, start;
    logic [7:0]                pay [NPAY];
    logic [7:0]                csum;
    logic [7:0]                byte_sel;

    assign tick  = enable && (cnt_q == CW'(PERIOD_CYC - 1));
    assign start = tick || trig;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!enable || tick) cnt_d = '0;
    end

    // Payload byte k: channel k/BPC, most significant byte of each channel first.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < BPC; b++) begin
                pay[c*BPC + b] = snap_q[c*DATA_W + (BPC-1-b)*8 +: 8];
            end
        end
    end

    always_comb begin
        csum = seq_q;
        for (int k = 0; k < NPAY; k++) begin
            csum = csum + snap_q[k*8 +: 8];
        end
    end

    always_comb begin
        byte_sel = HEADER;
        if (idx_q == IW'(1)) byte_sel = seq_q;
        else if (idx_q == IW'(FLEN - 1)) byte_sel = csum;
        else begin
            for (int k = 0; k < NPAY; k++) begin
                if (idx_q == IW'(k + 2)) byte_sel = pay[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        seq_d   = seq_q;
        ovr_d   = ovr_q;
        fd_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d  = ch_data;
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND, S_WAIT: begin
                state_d = S_WAIT;
                if (tx_done) begin
                    if (idx_q == IW'(FLEN - 1)) begin
                        state_d = S_IDLE;
                        fd_d    = 1'b1;
                        seq_d   = seq_q + 8'd1;
                    end else begin
                        state_d = S_GAP;
                        idx_d   = idx_q + IW'(1);
                    end
                end
            end
            S_GAP:   state_d = S_SEND;
            default: state_d = S_IDLE;
        endcase
        // Requests arriving while a frame is in flight are dropped and counted.
        if (start && (state_q != S_IDLE) && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            seq_q   <= '0;
            ovr_q   <= '0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            seq_q   <= seq_d;
            ovr_q   <= ovr_d;
            fd_q    <= fd_d;
        end
    end

    assign tx_en      = (state_q == S_SEND) || (state_q == S_WAIT);
    assign busy       = (state_q != S_IDLE);
    assign tx_data    = tx_en ? byte_sel : 8'h00;
    assign frame_done = fd_q;
    assign seq        = seq_q;
    assign ovr_cnt    = ovr_q;

endmodule

// File: tb/tb_telemetry_framer.sv
// Bench for telemetry_framer: 2x8-bit and 1x16-bit instances, UART responders,
// expected-byte queues checked by independent monitors.
`timescale 1ns/1ps
module tb_telemetry_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    int          tests = 0;
    int          fails = 0;

    // 2 x 8-bit instance
    logic        enable8, trig8, resp8, spur8, done8;
    logic [15:0] ch8;
    logic [7:0]  tx_data8, seq8, ovr8;
    logic        tx_en8, busy8, fd8;
    int          delay8;
    logic [7:0]  exp8_q[$];
    int          byte_idx = 0;
    int          mon_state = 0;
    int          fd8_cnt = 0;
    int          exp_fd8 = 0;
    logic        prev_en8 = 1'b0;
    logic [7:0]  rise_data8 = 8'h00;

    // 1 x 16-bit instance
    logic        enable16, trig16, resp16, done16;
    logic [15:0] ch16;
    logic [7:0]  tx_data16, seq16, ovr16;
    logic        tx_en16, busy16, fd16;
    logic [7:0]  exp16_q[$];
    int          fd16_cnt = 0;

    assign done8  = resp8 | spur8;
    assign done16 = resp16;

    telemetry_framer #(.NUM_CH(2), .DATA_W(8), .PERIOD_CYC(20), .HEADER(8'hA5)) dut8 (
        .clk(clk), .rstn(rstn), .enable(enable8), .trig(trig8), .ch_data(ch8),
        .tx_done(done8), .tx_data(tx_data8), .tx_en(tx_en8), .busy(busy8),
        .frame_done(fd8), .seq(seq8), .ovr_cnt(ovr8)
    );

    telemetry_framer #(.NUM_CH(1), .DATA_W(16), .PERIOD_CYC(20), .HEADER(8'hA5)) dut16 (
        .clk(clk), .rstn(rstn), .enable(enable16), .trig(trig16), .ch_data(ch16),
        .tx_done(done16), .tx_data(tx_data16), .tx_en(tx_en16), .busy(busy16),
        .frame_done(fd16), .seq(seq16), .ovr_cnt(ovr16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push8(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] cs;
        cs = s + a + b;
        exp8_q.push_back(8'hA5);
        exp8_q.push_back(s);
        exp8_q.push_back(a);
        exp8_q.push_back(b);
        exp8_q.push_back(cs);
        exp_fd8++;
    endtask

    task automatic pulse_trig8();
        trig8 = 1'b1;
        cyc(1);
        trig8 = 1'b0;
    endtask

    // Returns at #1 of the cycle in which frame_done is high.
    task automatic wait_frame8(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (fd8) break;
        end
        check("frame8_done_seen", fd8, 1);
    endtask

    // UART responders: tx_done pulse a fixed delay after each tx_en rise.
    initial begin
        resp8 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_en8 && rstn) begin
                for (int k = 0; k < delay8; k++) begin
                    @(posedge clk);
                    if (!rstn) break;
                end
                #1;
                if (rstn) begin
                    resp8 = 1'b1;
                    @(posedge clk);
                    #1;
                    resp8 = 1'b0;
                end
            end
        end
    end

    initial begin
        resp16 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_en16 && rstn) begin
                repeat (5) @(posedge clk);
                #1;
                resp16 = 1'b1;
                @(posedge clk);
                #1;
                resp16 = 1'b0;
            end
        end
    end

    // Monitor for the 8-bit instance: byte order, stability and gap timing.
    always @(negedge clk) begin
        if (!rstn) begin
            exp8_q.delete();
            byte_idx  = 0;
            mon_state = 0;
            prev_en8  = 1'b0;
        end else begin
            if (mon_state == 1) begin
                check("gap_low", tx_en8, 0);
                check("gap_no_done", fd8, 0);
                mon_state = 2;
            end else if (mon_state == 2) begin
                check("gap_rise", tx_en8, 1);
                mon_state = 0;
            end else if (mon_state == 3) begin
                check("frame_done_pulse", fd8, 1);
                check("busy_end", busy8, 0);
                mon_state = 0;
            end
            if (tx_en8 && !prev_en8) rise_data8 = tx_data8;
            if (tx_en8 && done8) begin
                if (exp8_q.size() == 0) begin
                    check("byte8_unexpected", tx_data8, 9'h100);
                end else begin
                    check("byte8", tx_data8, exp8_q.pop_front());
                end
                check("byte8_stable", tx_data8, rise_data8);
                byte_idx++;
                if (byte_idx == 5) begin
                    byte_idx  = 0;
                    mon_state = 3;
                end else begin
                    mon_state = 1;
                end
            end
            if (fd8) fd8_cnt++;
            prev_en8 = tx_en8;
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (tx_en16 && done16) begin
                if (exp16_q.size() == 0) check("byte16_unexpected", tx_data16, 9'h100);
                else check("byte16", tx_data16, exp16_q.pop_front());
            end
            if (fd16) fd16_cnt++;
        end
    end

    initial begin
        logic [7:0] s;
        rstn = 1'b0; enable8 = 1'b0; trig8 = 1'b0; spur8 = 1'b0; ch8 = 16'h3412;
        enable16 = 1'b0; trig16 = 1'b0; ch16 = 16'h1234; delay8 = 5;
        cyc(3);
        check("rst_tx_en", tx_en8, 0);
        check("rst_busy", busy8, 0);
        check("rst_tx_data", tx_data8, 0);
        check("rst_fd", fd8, 0);
        check("rst_seq", seq8, 0);
        check("rst_ovr", ovr8, 0);
        rstn = 1'b1;
        cyc(2);

        // 16-bit channel, manual trigger only
        exp16_q.push_back(8'hA5); exp16_q.push_back(8'h00);
        exp16_q.push_back(8'h12); exp16_q.push_back(8'h34); exp16_q.push_back(8'h46);
        trig16 = 1'b1; cyc(1); trig16 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (fd16) break;
        end
        check("frame16_done_seen", fd16, 1);
        check("seq16_after", seq16, 8'h01);
        cyc(100);
        check("no_auto16_busy", busy16, 0);
        check("no_auto16_frames", fd16_cnt, 1);

        // Frame from the period tick; samples changed mid-frame must not leak
        push8(8'h00, 8'h12, 8'h34);
        enable8 = 1'b1;
        cyc(20);
        enable8 = 1'b0;
        check("tick_started", busy8, 1);
        ch8 = 16'hFFFF;
        wait_frame8(200);
        ch8 = 16'h3412;
        check("seq_after_1", seq8, 8'h01);
        // Start in the frame_done cycle is accepted
        push8(8'h01, 8'h12, 8'h34);
        pulse_trig8();
        check("busy_b2b", busy8, 1);
        wait_frame8(200);
        check("seq_after_2", seq8, 8'h02);
        check("ovr_b2b", ovr8, 0);

        // Spurious tx_done while idle
        cyc(2);
        spur8 = 1'b1; cyc(1); spur8 = 1'b0;
        cyc(3);
        check("spur_busy", busy8, 0);
        check("spur_seq", seq8, 8'h02);

        // Tick and trig in the same idle cycle: one frame, no overrun
        push8(8'h02, 8'h12, 8'h34);
        enable8 = 1'b1;
        cyc(19);
        trig8 = 1'b1;
        cyc(1);
        trig8 = 1'b0; enable8 = 1'b0;
        wait_frame8(200);
        cyc(30);
        check("coinc_ovr", ovr8, 0);
        check("coinc_frames", fd8_cnt, exp_fd8);
        check("seq_after_3", seq8, 8'h03);

        // Overrun: long tx_done delay, three ticks and a trigger while busy
        delay8 = 30;
        push8(8'h03, 8'h12, 8'h34);
        pulse_trig8();
        cyc(5);
        enable8 = 1'b1;
        cyc(60);
        enable8 = 1'b0;
        check("ovr_busy", busy8, 1);
        check("ovr_ticks", ovr8, 8'd3);
        pulse_trig8();
        check("ovr_trig", ovr8, 8'd4);
        // Start in the cycle tx_done completes the last byte is dropped
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            if (done8 && tx_en8 && byte_idx == 4) break;
        end
        check("last_done_seen", done8 && tx_en8, 1);
        trig8 = 1'b1;
        @(posedge clk); #1;
        trig8 = 1'b0;
        check("ovr_last_byte", ovr8, 8'd5);
        cyc(3);
        check("drop_no_frame", busy8, 0);
        check("seq_after_4", seq8, 8'h04);

        // Reset during byte 2
        delay8 = 5;
        push8(8'h04, 8'h12, 8'h34);
        pulse_trig8();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (byte_idx == 1 && tx_en8) break;
        end
        check("byte2_reached", tx_en8, 1);
        #1 rstn = 1'b0;
        #1;
        check("mid_rst_tx_en", tx_en8, 0);
        check("mid_rst_busy", busy8, 0);
        check("mid_rst_seq", seq8, 0);
        check("mid_rst_ovr", ovr8, 0);
        exp_fd8--;
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        cyc(2);
        push8(8'h00, 8'h12, 8'h34);
        pulse_trig8();
        wait_frame8(200);
        check("seq_after_rst", seq8, 8'h01);

        // Sequence wrap with 0x0101 samples: seq FF -> csum 01, seq 00 -> csum 02
        ch8 = 16'h0101;
        delay8 = 1;
        s = 8'h01;
        for (int i = 0; i < 256; i++) begin
            push8(s, 8'h01, 8'h01);
            pulse_trig8();
            wait_frame8(100);
            if (s == 8'hFF) check("seq_wrap", seq8, 8'h00);
            s = s + 8'd1;
        end
        check("seq_after_wrap", seq8, 8'h01);

        cyc(10);
        check("exp8_drained", exp8_q.size(), 0);
        check("exp16_drained", exp16_q.size(), 0);
        check("frames8_total", fd8_cnt, exp_fd8);
        check("frames16_total", fd16_cnt, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/telemetry_framer.md
Name: telemetry_framer

Overview:
Periodic multi-channel telemetry packetiser feeding the existing byte-wide UART transmitter through its level-enable/done handshake. On a programmable period tick or a manual trigger it snapshots NUM_CH sample words and sends one framed packet: header, sequence number, payload bytes and checksum. It generalises the fixed half-second single-byte send path to N channels, 8- or 16-bit samples, framing, and overrun accounting.

Parameters:
NUM_CH, 2, number of sample channels (1..8)
DATA_W, 8, bits per channel; only 8 or 16 are legal; a 16-bit channel is sent big-endian as two bytes
PERIOD_CYC, 10000000, clk cycles between automatic frames
HEADER, 8'hA5, first byte of every frame

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
enable  input  1  1 = periodic frames on; 0 = period counter held at 0
trig  input  1  single-cycle manual frame request
ch_data  input  NUM_CH*DATA_W  channel samples; channel 0 in the LSBs
tx_done  input  1  single-cycle pulse from the UART transmitter when its byte completes
tx_data  output  8  byte presented to the transmitter
tx_en  output  1  transmit request, held high until tx_done
busy  output  1  frame in progress
frame_done  output  1  single-cycle pulse after the last byte completes
seq  output  8  sequence number of the next frame
ovr_cnt  output  8  saturating count of dropped start requests

Behaviour:
- Reset: all outputs 0, period counter 0, FSM in IDLE. Reset mid-frame drops tx_en in the same cycle; no partial frame resumes.
- Period counter: when enable=1, counts 0..PERIOD_CYC-1 and wraps. tick=1 in the cycle the count equals PERIOD_CYC-1. When enable=0, the counter is cleared to 0 and tick=0.
- start = tick | trig. If tick and trig are both high in one cycle, only one frame starts.
- Frame length L = 3 + NUM_CH*DATA_W/8.
  - Byte order: HEADER, seq, ch0 bytes, ch1 bytes, ..., checksum.
  - checksum = 8-bit modulo-256 sum of seq and all payload bytes; HEADER is excluded.
- FSM states: IDLE, SEND, WAIT, GAP.
  - IDLE: start at cycle T registers the ch_data snapshot and seq at the edge ending T. From T+1: busy=1, tx_en=1, tx_data=HEADER (state SEND/WAIT).
  - WAIT: tx_data is stable while tx_en=1. When tx_done=1 in cycle D, tx_en=0 in cycle D+1.
  - If the byte was not the last, D+1 is GAP (tx_en=0). The next byte is presented with tx_en=1 from D+2.
  - If the byte was the last, in cycle D+1: frame_done=1, busy=0, seq incremented (0xFF wraps to 0x00), state IDLE.
- tx_done while tx_en=0 is ignored.
- Snapshot: the payload comes only from the latched snapshot. ch_data changes during a frame have no effect.
- Overrun: start while busy=1 (including cycle D of the last byte) is dropped. ovr_cnt increments by 1 and saturates at 0xFF. A start in cycle D+1 is accepted.
- Disabling mid-frame: enable falling mid-frame does not abort the frame; the current frame completes. Only the counter clears.
- seq increments only on completed frames.

Test Plan:
- NUM_CH=2, DATA_W=8, PERIOD_CYC=20; ch_data=16'h3412, enable=1; tx_done returned 5 cycles after each tx_en rise -> bytes A5,00,12,34,46; frame_done once; seq=01. Second frame -> A5,01,12,34,47.
- Handshake timing: tx_en falls the cycle after tx_done, stays low exactly one cycle, then rises with the new tx_data. tx_data is constant while tx_en=1. A spurious tx_done while tx_en=0 -> no effect.
- DATA_W=16, NUM_CH=1; ch_data=16'h1234, trig pulse, enable=0 -> bytes A5,00,12,34,46. No automatic frames while enable=0.
- Overrun: tx_done delay 30 cycles so the frame exceeds the period -> each tick during busy raises ovr_cnt by 1. trig and tick in the same idle cycle -> one frame, ovr_cnt unchanged.
- Wrap: run 256 frames with ch_data=16'h0101 -> frame with seq FF has checksum 0x01; next seq=00, checksum 0x02.
- Reset asserted during byte 2 -> tx_en, busy, seq, ovr_cnt are 0 immediately. After release, the next start emits a full frame beginning with A5,00.
